// File: rtl/qdr2_b4_sram_pkg.sv
// qdr2_pkg: shared constants, types and lane-merge helper
// for the QDR-II burst-of-4 SRAM model.
package qdr2_pkg;

  localparam int QDR2_BURST_LEN     = 4;
  localparam int QDR2_LANE_W        = 9;
  localparam int QDR2_LANES         = 4;
  localparam int QDR2_READ_LAT_HALF = 3;

  typedef logic [QDR2_LANES*QDR2_LANE_W-1:0] qdr2_word_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT01,
    BEAT23
  } qdr2_port_state_t;

  function automatic qdr2_word_t qdr2_merge(
    input qdr2_word_t            i_old,
    input qdr2_word_t            i_new,
    input logic [QDR2_LANES-1:0] i_we
  );
    qdr2_word_t w_res;
    w_res = i_old;
    for (int i = 0; i < QDR2_LANES; i++) begin
      if (i_we[i]) begin
        w_res[i*QDR2_LANE_W +: QDR2_LANE_W] =
          i_new[i*QDR2_LANE_W +: QDR2_LANE_W];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/qdr2_b4_sram_port_seq.sv
// qdr2_port_seq: per-port burst sequencer (busy state,
// even-beat counter, latched burst address).
module qdr2_port_seq
  import qdr2_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_block,
  input  logic [AW-1:0] i_addr,
  output logic          o_free,
  output logic          o_act,
  output logic [1:0]    o_beat,
  output logic [AW-1:0] o_addr
);

  qdr2_port_state_t r_state;
  logic [1:0]       r_beat;
  logic [AW-1:0]    r_addr;
  logic             w_acc;

  // Only the edge right after an accept is blocked.
  assign o_free = (r_state != BEAT01);
  assign o_act  = (r_state != IDLE);
  assign o_beat = r_beat;
  assign o_addr = r_addr;
  assign w_acc  = i_req & o_free & ~i_block;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
    end else if (w_acc) begin
      r_state <= BEAT01;
      r_beat  <= '0;
      r_addr  <= i_addr;
    end else begin
      unique case (r_state)
        BEAT01: begin
          r_state <= BEAT23;
          r_beat  <= r_beat + 2'd2;
        end
        default: begin
          r_state <= IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/qdr2_b4_sram.sv
// qdr2_b4_sram: QDR-II B4 x36 SRAM model, DDR on K.
// QDR2_BYTE_WRITE_EN enables per-lane BWS masking.
module qdr2_b4_sram
  import qdr2_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DEPTH_W = 19,
  parameter int DATA_W  = 36
) (
  input  logic              K,
  input  logic              Kb,
  input  logic              C,
  input  logic              Cb,
  input  logic              RSTb,
  input  logic              RPSb,
  input  logic              WPSb,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              BWS0,
  input  logic              BWS1,
  input  logic              BWS2,
  input  logic              BWS3,
  output logic [DATA_W-1:0] Q,
  output logic              CQ,
  output logic              CQb,
  input  logic              TCK,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  input  logic              ZQ,
  input  logic              DOFF
);

  logic               w_rd_free;
  logic               w_rd_act;
  logic [1:0]         w_rd_beat;
  logic [DEPTH_W-1:0] w_rd_addr;
  logic               w_wr_free;
  logic               w_wr_act;
  logic [1:0]         w_wr_beat;
  logic [DEPTH_W-1:0] w_wr_addr;
  logic [DEPTH_W-1:0] w_a;
  logic               w_rd_req;
  logic               w_wr_req;
  logic               w_wr_block;
  logic [QDR2_LANES-1:0] w_we;
  logic               w_unused;

  logic               r_rd_vld;
  logic               r_rd_hi;
  logic [DEPTH_W-1:0] r_rd_addr;
  logic               r_wr_vld;
  logic               r_wr_hi;
  logic [DEPTH_W-1:0] r_wr_addr;
  qdr2_word_t         r_q_rise;
  qdr2_word_t         r_q_fall;

  // Even beats live in r_mem_ev, odd beats in r_mem_od.
  qdr2_word_t r_mem_ev [2**DEPTH_W][2];
  qdr2_word_t r_mem_od [2**DEPTH_W][2];

  assign w_a        = A[DEPTH_W-1:0];
  assign w_rd_req   = ~RPSb;
  assign w_wr_req   = ~WPSb;
  assign w_wr_block = w_rd_req & w_rd_free;

`ifdef QDR2_BYTE_WRITE_EN
  assign w_we = ~{BWS3, BWS2, BWS1, BWS0};
`else
  assign w_we = '1;
`endif

  assign CQ  = K;
  assign CQb = ~K;
  assign TDO = 1'b0;
  assign Q   = K ? r_q_rise : r_q_fall;

  assign w_unused = ^{Kb, C, Cb, TCK, TMS, TDI, ZQ,
                      DOFF, A, BWS0, BWS1, BWS2, BWS3,
                      w_rd_beat[0], w_wr_beat[0],
                      w_wr_free};

  qdr2_port_seq #(.AW(DEPTH_W)) u_rd_seq (
    .i_clk   (K),
    .i_rst_n (RSTb),
    .i_req   (w_rd_req),
    .i_block (1'b0),
    .i_addr  (w_a),
    .o_free  (w_rd_free),
    .o_act   (w_rd_act),
    .o_beat  (w_rd_beat),
    .o_addr  (w_rd_addr)
  );

  qdr2_port_seq #(.AW(DEPTH_W)) u_wr_seq (
    .i_clk   (K),
    .i_rst_n (RSTb),
    .i_req   (w_wr_req),
    .i_block (w_wr_block),
    .i_addr  (w_a),
    .o_free  (w_wr_free),
    .o_act   (w_wr_act),
    .o_beat  (w_wr_beat),
    .o_addr  (w_wr_addr)
  );

  always_ff @(posedge K or negedge RSTb) begin
    if (!RSTb) begin
      r_rd_vld  <= 1'b0;
      r_rd_hi   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_hi   <= 1'b0;
      r_wr_addr <= '0;
      r_q_rise  <= '0;
    end else begin
      r_rd_vld  <= w_rd_act;
      r_rd_hi   <= w_rd_beat[1];
      r_rd_addr <= w_rd_addr;
      r_wr_vld  <= w_wr_act;
      r_wr_hi   <= w_wr_beat[1];
      r_wr_addr <= w_wr_addr;
      if (r_rd_vld)
        r_q_rise <= r_mem_od[r_rd_addr][r_rd_hi];
      else
        r_q_rise <= r_q_fall;
    end
  end

  always_ff @(negedge K or negedge RSTb) begin
    if (!RSTb)
      r_q_fall <= '0;
    else if (r_rd_vld)
      r_q_fall <= r_mem_ev[r_rd_addr][r_rd_hi];
    else
      r_q_fall <= r_q_rise;
  end

  always_ff @(posedge K) begin
    if (w_wr_act)
      r_mem_ev[w_wr_addr][w_wr_beat[1]] <= qdr2_merge(
        r_mem_ev[w_wr_addr][w_wr_beat[1]], D, w_we);
  end

  always_ff @(negedge K) begin
    if (r_wr_vld)
      r_mem_od[r_wr_addr][r_wr_hi] <= qdr2_merge(
        r_mem_od[r_wr_addr][r_wr_hi], D, w_we);
  end

endmodule

// File: tb/tb_qdr2_b4_sram.sv
// tb_qdr2_b4_sram: directed checks of the QDR-II B4 model
// (DEPTH_W=10 so upper address bits alias).
module tb_qdr2_b4_sram;

  logic        K = 1'b0;
  logic        RSTb;
  logic        RPSb;
  logic        WPSb;
  logic [18:0] A;
  logic [35:0] D;
  logic [3:0]  bws;
  logic [35:0] Q;
  logic        CQ;
  logic        CQb;
  logic        TDO;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 K = ~K;

  qdr2_b4_sram #(
    .ADDR_W  (19),
    .DEPTH_W (10),
    .DATA_W  (36)
  ) dut (
    .K    (K),
    .Kb   (~K),
    .C    (1'b0),
    .Cb   (1'b1),
    .RSTb (RSTb),
    .RPSb (RPSb),
    .WPSb (WPSb),
    .A    (A),
    .D    (D),
    .BWS0 (bws[0]),
    .BWS1 (bws[1]),
    .BWS2 (bws[2]),
    .BWS3 (bws[3]),
    .Q    (Q),
    .CQ   (CQ),
    .CQb  (CQb),
    .TCK  (1'b0),
    .TMS  (1'b0),
    .TDI  (1'b0),
    .TDO  (TDO),
    .ZQ   (1'b0),
    .DOFF (1'b1)
  );

  task automatic chk(input string tag,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic half();
    @(K);
    #1;
  endtask

  task automatic wr(input logic [18:0] a,
                    input logic [35:0] d0,
                    input logic [35:0] d1,
                    input logic [35:0] d2,
                    input logic [35:0] d3,
                    input logic [3:0]  b0,
                    input logic [3:0]  b13);
    WPSb = 1'b0;
    A    = a;
    half();
    WPSb = 1'b1;
    D    = d0;
    bws  = b0;
    half();
    half();
    D    = d1;
    bws  = b13;
    half();
    D    = d2;
    half();
    D    = d3;
    half();
  endtask

  task automatic rd_check(input string tag,
                          input logic [18:0] a,
                          input logic [35:0] e0,
                          input logic [35:0] e1,
                          input logic [35:0] e2,
                          input logic [35:0] e3);
    logic [35:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    RPSb = 1'b0;
    A    = a;
    half();
    RPSb = 1'b1;
    half();
    half();
    for (int i = 0; i < 4; i++) begin
      half();
      chk($sformatf("%s_b%0d", tag, i), Q, e[i]);
    end
    half();
  endtask

  logic [35:0] exp8 [8];
  logic [35:0] exp_b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    RSTb = 1'b0;
    RPSb = 1'b1;
    WPSb = 1'b1;
    A    = '0;
    D    = '0;
    bws  = 4'hF;
    #2;
    chk("rst_q", Q, 36'h0);
    chk("tdo", {35'd0, TDO}, 36'h0);
    @(negedge K);
    #1;
    RSTb = 1'b1;
    half();
    half();

    // write then overlapping read at n+2
    WPSb = 1'b0;
    A    = 19'h00010;
    half();
    WPSb = 1'b1;
    D    = 36'h111111111;
    bws  = 4'h0;
    half();
    half();
    D    = 36'h222222222;
    RPSb = 1'b0;
    half();
    D    = 36'h333333333;
    half();
    D    = 36'h444444444;
    RPSb = 1'b1;
    half();
    half();
    half();
    chk("wr_rd_b0", Q, 36'h111111111);
    half();
    chk("wr_rd_b1", Q, 36'h222222222);
    half();
    chk("wr_rd_b2", Q, 36'h333333333);
    half();
    chk("wr_rd_b3", Q, 36'h444444444);
    half();
    chk("q_hold", Q, 36'h444444444);

    // byte write on beat 0 only
    wr(19'h00010, 36'h1FF1FF1FF, 36'h222222222,
       36'h333333333, 36'h444444444, 4'b1110, 4'b1111);
`ifdef QDR2_BYTE_WRITE_EN
    exp_b0 = 36'h1111111FF;
`else
    exp_b0 = 36'h1FF1FF1FF;
`endif
    rd_check("bws", 19'h00010, exp_b0, 36'h222222222,
             36'h333333333, 36'h444444444);

    // port busy: 3 read requests, middle one ignored
    wr(19'h1, 36'h0A0000001, 36'h0A0000002,
       36'h0A0000003, 36'h0A0000004, 4'h0, 4'h0);
    wr(19'h2, 36'h0B0000001, 36'h0B0000002,
       36'h0B0000003, 36'h0B0000004, 4'h0, 4'h0);
    wr(19'h3, 36'h0C0000001, 36'h0C0000002,
       36'h0C0000003, 36'h0C0000004, 4'h0, 4'h0);
    exp8[0] = 36'h0A0000001; exp8[1] = 36'h0A0000002;
    exp8[2] = 36'h0A0000003; exp8[3] = 36'h0A0000004;
    exp8[4] = 36'h0C0000001; exp8[5] = 36'h0C0000002;
    exp8[6] = 36'h0C0000003; exp8[7] = 36'h0C0000004;
    RPSb = 1'b0;
    A    = 19'h1;
    half();
    A    = 19'h2;
    half();
    half();
    A    = 19'h3;
    half();
    chk("busy_b0", Q, exp8[0]);
    half();
    chk("busy_b1", Q, exp8[1]);
    RPSb = 1'b1;
    for (int i = 2; i < 8; i++) begin
      half();
      chk($sformatf("busy_b%0d", i), Q, exp8[i]);
    end
    half();

    // collision: read wins, write dropped
    wr(19'h20, 36'h0E0000001, 36'h0E0000002,
       36'h0E0000003, 36'h0E0000004, 4'h0, 4'h0);
    RPSb = 1'b0;
    WPSb = 1'b0;
    A    = 19'h20;
    half();
    RPSb = 1'b1;
    WPSb = 1'b1;
    D    = 36'hBADBADBAD;
    bws  = 4'h0;
    half();
    half();
    half();
    chk("coll_b0", Q, 36'h0E0000001);
    half();
    chk("coll_b1", Q, 36'h0E0000002);
    half();
    chk("coll_b2", Q, 36'h0E0000003);
    half();
    chk("coll_b3", Q, 36'h0E0000004);
    half();
    rd_check("coll_mem", 19'h20, 36'h0E0000001,
             36'h0E0000002, 36'h0E0000003, 36'h0E0000004);

    // reset between read beats 1 and 2
    RPSb = 1'b0;
    A    = 19'h1;
    half();
    RPSb = 1'b1;
    half();
    half();
    half();
    chk("rst_b0", Q, 36'h0A0000001);
    half();
    chk("rst_b1", Q, 36'h0A0000002);
    #1;
    RSTb = 1'b0;
    #1;
    chk("rst_now", Q, 36'h0);
    half();
    chk("rst_nob2", Q, 36'h0);
    RSTb = 1'b1;
    half();
    chk("rst_nob3", Q, 36'h0);
    half();
    chk("rst_idle", Q, 36'h0);
    rd_check("rst_mem", 19'h1, 36'h0A0000001,
             36'h0A0000002, 36'h0A0000003, 36'h0A0000004);

    // aliasing with DEPTH_W = 10
    wr(19'h00405, 36'h0F0000001, 36'h0F0000002,
       36'h0F0000003, 36'h0F0000004, 4'h0, 4'h0);
    rd_check("alias", 19'h00005, 36'h0F0000001,
             36'h0F0000002, 36'h0F0000003, 36'h0F0000004);

    // echo clocks, starting just after a falling edge
    for (int i = 0; i < 4; i++) begin
      half();
      chk("cq", {35'd0, CQ}, (i % 2 == 0) ? 36'h1 : 36'h0);
      chk("cqb", {35'd0, CQb}, (i % 2 == 0) ? 36'h0 : 36'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
